// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the data-memory responder.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int MEM_BYTES_DEF = 4096;
   localparam int LATENCY_DEF   = 2;
   localparam int CNT_W         = 4;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage: one byte-enabled write port and two little-endian word
// read ports. Reads past the last full word return 0. Contents are never reset.
module dmem_byte_array
   import riscv_mem_pkg::*;
#(
   parameter int  MEM_BYTES = MEM_BYTES_DEF,
   localparam int AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [3:0]    wr_be,
   input  logic [31:0]   rsp_addr,
   output logic [31:0]   rsp_rdata,
   input  logic [31:0]   dbg_addr,
   output logic [31:0]   dbg_rdata
);

   logic [7:0] mem_q [MEM_BYTES];

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      logic [31:0] w;
      w = '0;
      if (a <= 32'(MEM_BYTES - 4)) begin
         for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = mem_q[AW'(a[AW-1:0] + AW'(i))];
         end
      end
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem_q[AW'(wr_idx + AW'(i))] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rsp_rdata = rd_word(rsp_addr);
      dbg_rdata = rd_word(dbg_addr);
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with one outstanding access.
//   state | meaning
//   IDLE  | ready for a request (only state with req_ready=1)
//   WAIT  | counting down remaining latency
//   RESP  | response presented, held until rsp_ready
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int LATENCY   = LATENCY_DEF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   input  logic [31:0] dbg_addr,
   output logic [31:0] dbg_rdata
);

   localparam int AW = $clog2(MEM_BYTES);

   dmem_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
   logic             we_q, err_q, err_d;
   logic [3:0]       be_q;

   logic             accept, enter_resp, wr_en;
   logic [31:0]      cur_addr, cur_wdata, arr_rdata;
   logic             cur_we, cur_err;
   logic [3:0]       cur_be;

   assign accept = req_valid && (state_q == IDLE);

   // With LATENCY=1 the commit happens on the accept edge, so use the live request.
   always_comb begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_we    = we_q;
      cur_be    = be_q;
      if (state_q == IDLE) begin
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_we    = req_we;
         cur_be    = req_be;
      end
   end

   assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr > 32'(MEM_BYTES - 4));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata_d = (cur_we || cur_err) ? 32'h0 : arr_rdata;
   assign err_d   = cur_err;
   // nrst gate keeps a request presented during reset from committing.
   assign wr_en   = enter_resp && cur_we && !cur_err && nrst;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            be_q    <= req_be;
         end
         if (enter_resp) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
   assign rsp_err   = rsp_valid && err_q;

   dmem_byte_array #(.MEM_BYTES(MEM_BYTES)) u_array (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_idx    (cur_addr[AW-1:0]),
      .wr_data   (cur_wdata),
      .wr_be     (cur_be),
      .rsp_addr  (cur_addr),
      .rsp_rdata (arr_rdata),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 1, 2 and 3
// share clock and reset; instance k has LATENCY k+1.
module tb_dmem_responder;

   localparam int MB = 4096;

   logic        clk = 1'b0;
   logic        nrst;
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];
   logic [31:0] dbg_addr  [3];
   logic [31:0] dbg_rdata [3];

   int chk_cnt = 0;
   int err_cnt = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] mdl  [3][MB];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(.MEM_BYTES(MB), .LATENCY(g + 1)) u_dut (
         .clk       (clk),
         .nrst      (nrst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .dbg_addr  (dbg_addr[g]),
         .dbg_rdata (dbg_rdata[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a > 32'(MB - 4));
   endfunction

   function automatic logic [31:0] mword(input int k, input logic [31:0] a);
      if (a > 32'(MB - 4)) return 32'h0;
      return {mdl[k][a+3], mdl[k][a+2], mdl[k][a+1], mdl[k][a]};
   endfunction

   task automatic chk_dbg(input int k, input logic [31:0] a);
      dbg_addr[k] = a;
      #1;
      chk("dbg", dbg_rdata[k], mword(k, a));
   endtask

   task automatic poison(input int k);
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h10;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'hF;
   endtask

   // One access: predict, push, drive, measure latency, optionally stall, pop and compare.
   task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold);
      exp_t e;
      int   n;
      e.err   = bad_addr(addr);
      e.rdata = (we || e.err) ? 32'h0 : mword(k, addr);
      if (we && !e.err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mdl[k][addr + 32'(i)] = wdata[8*i +: 8];
      sb_q.push_back(e);

      @(negedge clk);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_be[k]    = be;
      n = 0;
      while (!req_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 20), 1);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      n = 1;
      while (!rsp_valid[k] && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, k + 1);

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         poison(k);
         req_valid[k] = (h == 1);
         chk("hold_valid", rsp_valid[k], 1);
         chk("hold_rdata", rsp_rdata[k], sb_q[0].rdata);
         chk("hold_err", rsp_err[k], sb_q[0].err);
         chk("hold_ready", req_ready[k], 0);
      end

      @(negedge clk);
      poison(k);
      req_valid[k] = 1'b1;
      rsp_ready[k] = 1'b1;
      e = sb_q.pop_front();
      chk("rsp_valid", rsp_valid[k], 1);
      chk("rsp_rdata", rsp_rdata[k], e.rdata);
      chk("rsp_err", rsp_err[k], e.err);
      @(posedge clk);
      #1;
      rsp_ready[k] = 1'b0;
      req_valid[k] = 1'b0;
      chk("idle_ready", req_ready[k], 1);
      chk("idle_rvalid", rsp_valid[k], 0);
   endtask

   initial begin
      exp_t e;
      nrst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_valid[k] = 1'b0;
         req_we[k]    = 1'b0;
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         req_be[k]    = '0;
         rsp_ready[k] = 1'b0;
         dbg_addr[k]  = '0;
      end
      #3;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", req_ready[k], 1);
         chk("rst_rvalid", rsp_valid[k], 0);
         chk("rst_rdata", rsp_rdata[k], 0);
         chk("rst_err", rsp_err[k], 0);
      end
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      // LATENCY=2: store/load, partial store, errors, stall
      do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      chk_dbg(1, 32'h10);
      do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 5);
      do_req(1, 1'b1, 32'h10, 32'h00000055, 4'h1, 0);
      do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 0);
      do_req(1, 1'b1, 32'h0, 32'h11223344, 4'hF, 0);
      do_req(1, 1'b0, 32'h12, 32'h0, 4'hF, 0);
      do_req(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0);
      chk_dbg(1, 32'h0);
      chk_dbg(1, 32'h1000);
      do_req(1, 1'b1, 32'h11, 32'h0, 4'hF, 2);
      chk_dbg(1, 32'h10);
      do_req(1, 1'b1, 32'hFFC, 32'hA1B2C3D4, 4'hF, 0);
      do_req(1, 1'b0, 32'hFFC, 32'h0, 4'h0, 1);

      // LATENCY=3: reset one cycle after accepting a store aborts it
      do_req(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 32'h20;
      req_wdata[2] = 32'h12345678;
      req_be[2]    = 4'hF;
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      chk("abort_acc", req_ready[2], 0);
      @(posedge clk);
      #1;
      nrst = 1'b0;
      #1;
      chk("abort_rvalid", rsp_valid[2], 0);
      chk("abort_ready", req_ready[2], 1);
      chk("abort_rdata", rsp_rdata[2], 0);
      chk("abort_err", rsp_err[2], 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      chk_dbg(2, 32'h20);
      do_req(2, 1'b0, 32'h20, 32'h0, 4'hF, 0);

      // LATENCY=1: back-to-back loads with rsp_ready held high
      do_req(0, 1'b1, 32'h10, 32'hA5A50F0F, 4'hF, 0);
      do_req(0, 1'b1, 32'h14, 32'h01020304, 4'hF, 0);
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_be[0]    = 4'h0;
      for (int c = 0; c < 8; c++) begin
         if (c % 2 == 0) req_addr[0] = (c % 4 == 0) ? 32'h10 : 32'h14;
         chk("b2b_ready", req_ready[0], 32'(c % 2 == 0));
         chk("b2b_rvalid", rsp_valid[0], 32'(c % 2 == 1));
         if (c % 2 == 0) begin
            e.rdata = mword(0, req_addr[0]);
            e.err   = 1'b0;
            sb_q.push_back(e);
         end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("b2b_rdata", rsp_rdata[0], e.rdata);
            chk("b2b_err", rsp_err[0], e.err);
         end
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b0;
      chk("sb_empty", sb_q.size(), 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 4096, giving the byte capacity of the memory.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request accept to response valid; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: the store data.
REQ-010 The block SHALL have port req_be, input, 4 bits: the store byte enables, with bit i covering byte addr+i.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: the load data, little-endian.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned or out of range.
REQ-015 The block SHALL have port dbg_addr, input, 32 bits: the word address for the checker read port.
REQ-016 The block SHALL have port dbg_rdata, output, 32 bits: a combinational read of bytes dbg_addr+3..dbg_addr, returning 0 when the address is out of range.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 in IDLE only and 0 in every other state.
REQ-019 An accept occurs on a rising edge with req_valid=1 and req_ready=1; on an accept the block SHALL latch addr, we, wdata and be.
REQ-020 On an accept with LATENCY=1 the FSM SHALL go from IDLE to RESP; with LATENCY>1 it SHALL go from IDLE to WAIT with the counter loaded to LATENCY-2.
REQ-021 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-022 rsp_valid SHALL rise exactly LATENCY rising edges after the accept edge.
REQ-023 The store commit and the read-data capture SHALL both occur on the edge that enters RESP, never earlier.
REQ-024 A store SHALL write only the enabled bytes; disabled bytes SHALL keep their values, and rsp_rdata SHALL be 0 for a store.
REQ-025 A load SHALL return {mem[a+3], mem[a+2], mem[a+1], mem[a]} and SHALL ignore req_be.
REQ-026 An error access is one with addr[1:0]!=0 or addr>MEM_BYTES-4; for an error access, rsp_err SHALL be 1, rsp_rdata SHALL be 0, no write SHALL occur, and latency SHALL be unchanged.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; on the edge with rsp_valid=1 and rsp_ready=1 the FSM SHALL go to IDLE.
REQ-028 The minimum request spacing SHALL be LATENCY+1 cycles, which includes a mandatory IDLE cycle and allows no overlap.
REQ-029 If req_valid=1 and rsp_ready=1 in the same cycle while in RESP, the request SHALL NOT be accepted; the core holds it until IDLE.
REQ-030 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-031 dbg_rdata SHALL reflect committed contents only, SHALL be independent of the FSM, and SHALL see a commit in the cycle after the commit edge.

Reset
REQ-032 nrst=0 SHALL immediately force the state to IDLE, the counter to 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-033 A reset during WAIT SHALL abort the access, and a store that has not yet committed SHALL NOT be written.
REQ-034 Reset SHALL NOT clear memory contents; the contents are undefined at power-up and preserved across nrst.

Structure
REQ-035 Package riscv_mem_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP), the MEM_BYTES default, the LATENCY default and the 4-bit counter width.
REQ-036 The byte storage with its byte-enabled write and little-endian word read SHALL be the single sub-module dmem_byte_array, which has two read ports (response and debug) and one write port.

Verification
REQ-037 With LATENCY=2, a store to addr 0x10 with wdata 0xDEADBEEF and be 0xF SHALL make rsp_valid rise 2 edges after accept with rsp_err=0, and afterwards dbg_addr=0x10 SHALL return 0xDEADBEEF.
REQ-038 A load from 0x10 after REQ-037 SHALL return rsp_rdata=0xDEADBEEF; a store of 0x00000055 with be 0x1, followed by a load, SHALL return 0xDEADBE55.
REQ-039 A load from 0x12 SHALL give rsp_err=1 with rdata=0, and a store to 0x1000 with MEM_BYTES=4096 SHALL give rsp_err=1 with memory unchanged per dbg.
REQ-040 Holding rsp_ready=0 for 5 cycles in RESP SHALL keep rsp_valid, rdata and err stable and req_ready=0, and a req_valid pulse during those cycles SHALL NOT be accepted.
REQ-041 nrst asserted one cycle after accepting a store of 0x12345678 to 0x20 (LATENCY=3) SHALL give rsp_valid=0 and req_ready=1 immediately, and dbg at 0x20 SHALL equal its prior value.
REQ-042 With LATENCY=1 and back-to-back requests under rsp_ready=1, accepts SHALL occur every 2 cycles and rsp_valid SHALL rise 1 edge after each accept.
